// File: rtl/mult.sv
`default_nettype none
// ============================================================================
//  Module      : mult
//  Description : 32x32 signed multiplier using radix-2 Booth recoding, one
//                recoding step per clock. The operation runs as an
//                IDLE -> RUN -> DONE sequence: the result appears 32 cycles
//                after the capture edge and is held while mult_ctrl stays
//                high. Dropping mult_ctrl during RUN abandons the operation
//                and leaves the previous result in place.
//  Ports       : clk       - clock, rising edge
//                reset     - synchronous active-high reset
//                mult_ctrl - request / hold (high), return to idle (low)
//                a, b      - signed multiplicand / multiplier (32 bit)
//                hi, lo    - upper / lower halves of the 64-bit product
//                mult_end  - high while hi/lo hold the current result
//  Options     : MULT_ZERO_BYPASS_EN - when defined, a zero operand at the
//                capture edge completes after one cycle with a zero result.
//  Revision    : 1.0 - initial release
// ============================================================================
module mult (
    input  logic        clk,
    input  logic        reset,
    input  logic        mult_ctrl,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        mult_end
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [5:0] c_STEPS = 6'd32;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_m;
    logic [32:0] r_acc;
    logic [31:0] r_q;
    logic        r_qm1;
    logic [5:0]  r_cnt;

    logic [31:0] w_m_nxt;
    logic [32:0] w_acc_nxt;
    logic [31:0] w_q_nxt;
    logic        w_qm1_nxt;
    logic [5:0]  w_cnt_nxt;
    logic [31:0] w_hi_nxt;
    logic [31:0] w_lo_nxt;
    logic        w_end_nxt;

    // Combinational Booth step: add/subtract M, then arithmetic shift of
    // {acc,Q,Q(-1)}. The 33-bit accumulator absorbs the -(-2^31) case.
    logic [32:0] w_m_ext;
    logic [32:0] w_sum;
    logic [32:0] w_acc_sh;
    logic [31:0] w_q_sh;

    always_comb begin
        w_m_ext = {r_m[31], r_m};
        unique case ({r_q[0], r_qm1})
            2'b01:   w_sum = r_acc + w_m_ext;
            2'b10:   w_sum = r_acc - w_m_ext;
            default: w_sum = r_acc;
        endcase
        w_acc_sh = {w_sum[32], w_sum[32:1]};
        w_q_sh   = {w_sum[0], r_q[31:1]};
    end

`ifdef MULT_ZERO_BYPASS_EN
    // Remembers that the captured request had a zero operand.
    logic r_zero;
    logic w_zero_nxt;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_m_nxt     = r_m;
        w_acc_nxt   = r_acc;
        w_q_nxt     = r_q;
        w_qm1_nxt   = r_qm1;
        w_cnt_nxt   = r_cnt;
        w_hi_nxt    = hi;
        w_lo_nxt    = lo;
        w_end_nxt   = mult_end;
`ifdef MULT_ZERO_BYPASS_EN
        w_zero_nxt  = r_zero;
`endif
        unique case (r_state)
            S_IDLE: begin
                w_end_nxt = 1'b0;
                if (mult_ctrl) begin
                    w_m_nxt     = a;
                    w_q_nxt     = b;
                    w_qm1_nxt   = 1'b0;
                    w_acc_nxt   = 33'd0;
                    w_cnt_nxt   = c_STEPS;
`ifdef MULT_ZERO_BYPASS_EN
                    w_zero_nxt  = (a == 32'd0) || (b == 32'd0);
`endif
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (!mult_ctrl) begin
                    // Abort: results from the previous operation stay put.
                    w_end_nxt   = 1'b0;
                    w_state_nxt = S_IDLE;
                end
`ifdef MULT_ZERO_BYPASS_EN
                else if (r_zero) begin
                    w_hi_nxt    = 32'd0;
                    w_lo_nxt    = 32'd0;
                    w_end_nxt   = 1'b1;
                    w_state_nxt = S_DONE;
                end
`endif
                else begin
                    w_acc_nxt = w_acc_sh;
                    w_q_nxt   = w_q_sh;
                    w_qm1_nxt = r_q[0];
                    w_cnt_nxt = r_cnt - 6'd1;
                    if (r_cnt == 6'd1) begin
                        // Last step: acc[32] is only sign extension.
                        w_hi_nxt    = w_acc_sh[31:0];
                        w_lo_nxt    = w_q_sh;
                        w_end_nxt   = 1'b1;
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (!mult_ctrl) begin
                    w_end_nxt   = 1'b0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_end_nxt   = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_m      <= 32'd0;
            r_acc    <= 33'd0;
            r_q      <= 32'd0;
            r_qm1    <= 1'b0;
            r_cnt    <= 6'd0;
            hi       <= 32'd0;
            lo       <= 32'd0;
            mult_end <= 1'b0;
`ifdef MULT_ZERO_BYPASS_EN
            r_zero   <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_m      <= w_m_nxt;
            r_acc    <= w_acc_nxt;
            r_q      <= w_q_nxt;
            r_qm1    <= w_qm1_nxt;
            r_cnt    <= w_cnt_nxt;
            hi       <= w_hi_nxt;
            lo       <= w_lo_nxt;
            mult_end <= w_end_nxt;
`ifdef MULT_ZERO_BYPASS_EN
            r_zero   <= w_zero_nxt;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mult.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult
//  Description : Self-checking bench for mult. A transaction-level model
//                (plain signed multiply plus a latency countdown) predicts
//                hi/lo/mult_end every cycle; directed cases pin known
//                products and latencies, then randomized operations with
//                aborts, mid-run operand changes and resets follow.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mult;

    logic        clk;
    logic        reset;
    logic        mult_ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        mult_end;

    int n_checks = 0;
    int n_errors = 0;
    bit check_en = 0;

    mult dut (
        .clk      (clk),
        .reset    (reset),
        .mult_ctrl(mult_ctrl),
        .a        (a),
        .b        (b),
        .hi       (hi),
        .lo       (lo),
        .mult_end (mult_end)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef MULT_ZERO_BYPASS_EN
    localparam int ZERO_LAT = 1;
`else
    localparam int ZERO_LAT = 32;
`endif

    // ---------------- reference model ----------------
    function automatic logic [63:0] smul(input logic [31:0] x, input logic [31:0] y);
        longint sx, sy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        return 64'(sx * sy);
    endfunction

    logic [31:0] exp_hi, exp_lo;
    logic        exp_end;
    bit          m_busy;
    int          m_left;
    logic [63:0] m_prod;

    always @(posedge clk) begin
        if (reset) begin
            exp_hi  <= 32'd0;
            exp_lo  <= 32'd0;
            exp_end <= 1'b0;
            m_busy  <= 1'b0;
            m_left  <= 0;
        end else if (m_busy) begin
            if (!mult_ctrl) begin
                m_busy  <= 1'b0;
                exp_end <= 1'b0;
            end else if (m_left == 1) begin
                exp_hi  <= m_prod[63:32];
                exp_lo  <= m_prod[31:0];
                exp_end <= 1'b1;
                m_busy  <= 1'b0;
            end else begin
                m_left <= m_left - 1;
            end
        end else if (exp_end) begin
            if (!mult_ctrl) exp_end <= 1'b0;
        end else if (mult_ctrl) begin
            m_busy <= 1'b1;
            m_prod <= smul(a, b);
            m_left <= ((a == 32'd0) || (b == 32'd0)) ? ZERO_LAT : 32;
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("hi_vs_model", 64'(hi), 64'(exp_hi));
            chk("lo_vs_model", 64'(lo), 64'(exp_lo));
            chk("end_vs_model", 64'(mult_end), 64'(exp_end));
        end
    end

    // ---------------- stimulus helpers ----------------
    // All helpers are entered and left shortly after a rising edge.
    task automatic start_op(input logic [31:0] av, input logic [31:0] bv);
        #2;
        a = av;
        b = bv;
        mult_ctrl = 1'b1;
        @(posedge clk);  // capture edge E0
    endtask

    task automatic wait_end(input string name, input int req_lat);
        int cyc;
        cyc = 0;
        while (cyc < 40) begin
            @(posedge clk);
            cyc++;
            #1;
            if (mult_end === 1'b1) break;
        end
        n_checks++;
        if (mult_end !== 1'b1) begin
            n_errors++;
            $display("FAIL %s_timeout: mult_end=%b after %0d cycles, required 1", name, mult_end, cyc);
        end
        if (req_lat > 0) chk({name, "_latency"}, 64'(cyc), 64'(req_lat));
    endtask

    task automatic release_ctrl();
        @(posedge clk);
        #2;
        mult_ctrl = 1'b0;
        @(posedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb;
        int kind, k;
        reset = 1'b1;
        mult_ctrl = 1'b0;
        a = 32'd0;
        b = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check_en = 1'b1;
        chk("reset_hi", 64'(hi), 64'd0);
        chk("reset_lo", 64'(lo), 64'd0);
        chk("reset_end", 64'(mult_end), 64'd0);
        reset = 1'b0;
        @(posedge clk);

        // 7 * -3, latency 32, then hold in DONE without restarting
        start_op(32'd7, 32'hFFFF_FFFD);
        wait_end("m7x3", 32);
        chk("m7x3_hi", 64'(hi), 64'hFFFF_FFFF);
        chk("m7x3_lo", 64'(lo), 64'hFFFF_FFEB);
        chk("m7x3_model_lo", 64'(exp_lo), 64'hFFFF_FFEB);
        repeat (5) @(posedge clk);
        #1;
        chk("hold_end", 64'(mult_end), 64'd1);
        chk("hold_lo", 64'(lo), 64'hFFFF_FFEB);
        release_ctrl();

        start_op(32'h8000_0000, 32'h8000_0000);
        wait_end("mmin", 32);
        chk("mmin_hi", 64'(hi), 64'h4000_0000);
        chk("mmin_lo", 64'(lo), 64'h0000_0000);
        chk("mmin_model_hi", 64'(exp_hi), 64'h4000_0000);
        release_ctrl();

        start_op(32'h7FFF_FFFF, 32'h7FFF_FFFF);
        wait_end("mmax", 32);
        chk("mmax_hi", 64'(hi), 64'h3FFF_FFFF);
        chk("mmax_lo", 64'(lo), 64'h0000_0001);
        release_ctrl();

        // operands changed mid-run must not matter
        start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (5) @(posedge clk);
        #2;
        a = 32'd5;
        b = 32'd5;
        wait_end("mneg1", 0);
        chk("mneg1_hi", 64'(hi), 64'd0);
        chk("mneg1_lo", 64'(lo), 64'd1);
        release_ctrl();

        // complete 3*4, then abort 9*9 part way
        start_op(32'd3, 32'd4);
        wait_end("m3x4", 32);
        chk("m3x4_lo", 64'(lo), 64'd12);
        release_ctrl();
        start_op(32'd9, 32'd9);
        repeat (10) @(posedge clk);
        #2;
        mult_ctrl = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_end", 64'(mult_end), 64'd0);
        chk("abort_hi", 64'(hi), 64'd0);
        chk("abort_lo", 64'(lo), 64'd12);
        @(posedge clk);

        // reset mid-run, then a fresh run with mult_ctrl still high
        start_op(32'd100, 32'd100);
        repeat (20) @(posedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_hi", 64'(hi), 64'd0);
        chk("rst_mid_lo", 64'(lo), 64'd0);
        chk("rst_mid_end", 64'(mult_end), 64'd0);
        reset = 1'b0;
        @(posedge clk);  // new E0
        wait_end("m100", 32);
        chk("m100_lo", 64'(lo), 64'd10000);
        chk("m100_hi", 64'(hi), 64'd0);
        release_ctrl();

        // zero operand
        start_op(32'd0, 32'h1234);
        wait_end("mzero", ZERO_LAT);
        chk("mzero_hi", 64'(hi), 64'd0);
        chk("mzero_lo", 64'(lo), 64'd0);
        release_ctrl();

        // randomized operations
        for (int i = 0; i < 60; i++) begin
            kind = int'($urandom_range(0, 5));
            ra = $urandom;
            rb = $urandom;
            if (kind == 0) begin
                if ($urandom_range(0, 1) == 0) ra = 32'd0; else rb = 32'd0;
            end else if (kind == 1) begin
                ra = ($urandom_range(0, 1) == 0) ? 32'h8000_0000 : 32'hFFFF_FFFF;
                rb = ($urandom_range(0, 1) == 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
            end
            start_op(ra, rb);
            k = int'($urandom_range(1, 31));
            kind = int'($urandom_range(0, 4));
            if (kind == 0) begin
                repeat (k) @(posedge clk);
                #2;
                mult_ctrl = 1'b0;
                @(posedge clk);
            end else if (kind == 1) begin
                repeat (k) @(posedge clk);
                #2;
                reset = 1'b1;
                mult_ctrl = 1'b0;
                @(posedge clk);
                #2;
                reset = 1'b0;
                @(posedge clk);
            end else begin
                if (kind == 2) begin
                    repeat (k) @(posedge clk);
                    #2;
                    a = $urandom;
                    b = $urandom;
                end
                wait_end("rand", 0);
                repeat (int'($urandom_range(0, 3))) @(posedge clk);
                release_ctrl();
            end
        end

        repeat (2) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
